// File: rtl/osnt_bram_pkg.sv
// Shared definitions for the packet BRAM replay engine: entry field offsets and FSM states.
package osnt_bram_pkg;

  localparam int unsigned TDATA_LSB = 0;
  localparam int unsigned TUSER_LSB = 512;
  localparam int unsigned TKEEP_LSB = 640;
  localparam int unsigned VLD_BIT   = 704;
  localparam int unsigned LAST_BIT  = 705;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/osnt_bram_replay_fifo.sv
// Two-entry registered output buffer; head entry drives the stream directly from flops.
module osnt_bram_replay_fifo #(
  parameter int unsigned WIDTH = 705
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent_q [2];
  logic [WIDTH-1:0] ent_d [2];
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    // Write lands at the post-pop tail so a simultaneous pop/push keeps order.
    if (push && (cnt_d != 2'd2)) begin
      ent_d[cnt_d[0]] = din;
      cnt_d           = cnt_d + 2'd1;
    end
    if (flush) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = ent_q[0];
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/osnt_bram_replay.sv
// Replays packet BRAM entries 0..last_addr as an AXI4-Stream master, optionally looping,
// with a credit-limited read pipeline feeding a two-entry output buffer.
module osnt_bram_replay
  import osnt_bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 736,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 128
) (
  input  logic                     bram_clk,
  input  logic                     bram_rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_WIDTH-1:0]    last_addr,
  input  logic [31:0]              replay_cnt,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              loops_done,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [DATA_WIDTH-1:0]    bram_wrdata,
  input  logic [DATA_WIDTH-1:0]    bram_rddata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int unsigned KW = TDATA_WIDTH / 8;
  localparam int unsigned PW = TDATA_WIDTH + TUSER_WIDTH + KW + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, last_q;
  logic [31:0]           cnt_q, loops_q, loops_nxt;
  logic                  inflight_q, last_tlast_q, stop_pend_q, done_q;

  logic          push, pop, flush, fifo_vld;
  logic [1:0]    fifo_cnt;
  logic [PW-1:0] fifo_din, fifo_dout;
  logic [2:0]    occ;
  logic          credit_ok, rd_en, wrap, final_loop;
  logic          head_last, at_bound, end_now;

  assign pop       = fifo_vld & m_axis_tready;
  assign head_last = fifo_dout[PW-1];
  // Boundary is judged after this cycle's pop: a tlast beat leaving now closes the packet.
  assign at_bound  = pop ? head_last : last_tlast_q;
  assign end_now   = (state_q != StIdle) & (stop | stop_pend_q) & at_bound;
  assign flush     = end_now;

  assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign credit_ok = occ < (3'd2 + {2'b00, pop});
  assign rd_en     = (state_q == StRun) & ~end_now & credit_ok;

  assign wrap       = (addr_q == last_q);
  assign loops_nxt  = (&loops_q) ? loops_q : loops_q + 32'd1;
  assign final_loop = (cnt_q != 32'd0) && (loops_nxt >= cnt_q);

  assign push     = inflight_q & bram_rddata[VLD_BIT];
  assign fifo_din = {bram_rddata[LAST_BIT], bram_rddata[TKEEP_LSB +: KW],
                     bram_rddata[TUSER_LSB +: TUSER_WIDTH], bram_rddata[TDATA_LSB +: TDATA_WIDTH]};

  if (DATA_WIDTH > LAST_BIT + 1) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^bram_rddata[DATA_WIDTH-1:LAST_BIT+1];
  end

  osnt_bram_replay_fifo #(
    .WIDTH(PW)
  ) u_fifo (
    .clk  (bram_clk),
    .rst  (bram_rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (fifo_din),
    .dout (fifo_dout),
    .valid(fifo_vld),
    .count(fifo_cnt)
  );

  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      loops_q      <= '0;
      inflight_q   <= 1'b0;
      last_tlast_q <= 1'b1;
      stop_pend_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      if (pop) begin
        last_tlast_q <= head_last;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StRun;
            addr_q       <= '0;
            last_q       <= last_addr;
            cnt_q        <= replay_cnt;
            loops_q      <= '0;
            last_tlast_q <= 1'b1;
            stop_pend_q  <= 1'b0;
          end
        end
        StRun: begin
          if (rd_en) begin
            if (wrap) begin
              addr_q  <= '0;
              loops_q <= loops_nxt;
              if (final_loop) begin
                state_q <= StDrain;
              end
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
          if (end_now) begin
            state_q     <= StDrain;
            stop_pend_q <= 1'b0;
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        StDrain: begin
          if (end_now) begin
            stop_pend_q <= 1'b0;
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (!fifo_vld && !inflight_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign loops_done    = loops_q;
  assign bram_addr     = addr_q;
  assign bram_en       = rd_en;
  assign bram_we       = 1'b0;
  assign bram_wrdata   = '0;
  assign m_axis_tvalid = fifo_vld;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = fifo_dout;

endmodule

// File: doc/osnt_bram_replay.md
Name: osnt_bram_replay

Overview:
- Read-side engine for the packet BRAM (UltraRAM). Drives the BRAM port and replays the stored 736-bit entries as an AXI4-Stream master.
- Sits between the BRAM and the generator TX path.
- Walks addresses 0..last_addr, optionally for N loops, and sustains one word per cycle under tready with 1-cycle BRAM read latency.

Parameters:
ADDR_WIDTH, 11, BRAM address width; depth 2**ADDR_WIDTH entries.
DATA_WIDTH, 736, BRAM entry width; must be >= 706.
TDATA_WIDTH, 512, stream data width.
TUSER_WIDTH, 128, stream user width.

Ports:
bram_clk  in  1  sole clock.
bram_rst  in  1  synchronous active-high reset.
start  in  1  pulse; begins replay when idle.
stop  in  1  pulse; graceful stop at the next packet boundary.
last_addr  in  ADDR_WIDTH  final entry address; sampled on start.
replay_cnt  in  32  loop count; 0 = loop until stop; sampled on start.
busy  out  1  high from the cycle after start until done.
done  out  1  1-cycle pulse when replay ends.
loops_done  out  32  completed loops; cleared on start.
bram_addr  out  ADDR_WIDTH  read address.
bram_en  out  1  read enable.
bram_we  out  1  tied 0.
bram_wrdata  out  DATA_WIDTH  tied 0.
bram_rddata  in  DATA_WIDTH  valid 1 cycle after bram_en.
m_axis_tdata  out  TDATA_WIDTH  entry[511:0].
m_axis_tuser  out  TUSER_WIDTH  entry[639:512].
m_axis_tkeep  out  TDATA_WIDTH/8  entry[703:640].
m_axis_tlast  out  1  entry[705].
m_axis_tvalid  out  1  word valid.
m_axis_tready  in  1  sink ready.

Behaviour:
- Reset: state IDLE. busy, done, bram_en and m_axis_tvalid are 0. bram_addr, loops_done and all m_axis data are 0. The buffer and the in-flight flag are cleared. Reset mid-replay aborts with no done pulse.
- Entry layout: [511:0] tdata, [639:512] tuser, [703:640] tkeep, [704] entry-valid, [705] tlast, rest ignored. Entries with entry-valid=0 are read and silently dropped. They still count toward address/loop progress.
- FSM IDLE -> RUN on start. RUN -> DRAIN when the final loop's last_addr read is issued, or when stop is seen. DRAIN -> IDLE with a done pulse.
- start while busy: ignored. stop while IDLE: ignored.
- Latency: start in cycle 0 gives bram_en=1 with addr 0 in cycle 1, the word captured at the end of cycle 2, and m_axis_tvalid=1 in cycle 3.
- Flow control: 2-entry output buffer. A read is issued in a cycle only if (occupancy + in-flight − pop-this-cycle) < 2. With tready held at 1, bram_en stays high every cycle (1 word/cycle).
- AXI-S rules: once tvalid is high, tvalid and all data are held stable until tready. No combinational path from tready to tvalid. bram_en may depend combinationally on the registered pop.
- Address wrap: after issuing last_addr the next address is 0 and loops_done increments in the same cycle. When loops_done reaches a nonzero replay_cnt, no further reads are issued. last_addr=0 replays a single entry per loop.
- Normal end: DRAIN waits for the buffer to empty and nothing to be in flight, then pulses done the following cycle.
- Stop mid-packet: reads continue until a word with tlast=1 is emitted. Buffered or in-flight words after it are discarded, then done follows.
- Stop at a packet boundary (last emitted word had tlast, or nothing emitted yet): the buffer is flushed immediately, tvalid is deasserted unless a word is mid-handshake, and done is asserted within 2 cycles.
- loops_done saturates at 2^32−1.

Decomposition:
- Package osnt_bram_pkg: field offsets/widths (TDATA_LSB, TUSER_LSB, TKEEP_LSB, VLD_BIT=704, LAST_BIT=705) and the FSM state enum.
- Sub-module osnt_bram_replay_fifo: 2-entry registered skid/credit buffer with push, pop, flush, count.

Test Plan:
- Reset and idle: bram_rst held for 4 cycles -> all outputs 0, bram_en never asserted.
- Single loop: 8 entries (2 packets of 4, tlast at addr 3 and 7), last_addr=7, replay_cnt=1, tready=1 -> tvalid first at cycle 3; 8 back-to-back beats; done at cycle 12; loops_done=1.
- Backpressure: same data, tready toggling 1/0 every cycle -> no word lost or duplicated, data stable while stalled, at most 2 reads outstanding.
- Loops with a dropped entry: last_addr=3, replay_cnt=3, entry 2 with vld=0 -> 9 beats emitted (addr 0,1,3 ×3), loops_done=3, done once.
- Stop mid-packet: replay_cnt=0, stop asserted after beat 2 of a 4-beat packet -> beats 3 and 4 emitted (tlast on 4), no further beats, done pulse.
- Start while busy and reset mid-run: a second start is ignored (address sequence unchanged); bram_rst at beat 5 -> tvalid=0 the next cycle, no done pulse, a new start restarts from addr 0.
